// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: direct-mapped I-cache lookup with single-line refill and flush sweep.
// Arrays are read synchronously from icNextReadAddrIn; hits are resolved against icReadAddrIn.
module icache_fetch_responder #(
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_INSNS  = 4,
    parameter int NUM_SETS    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     icNextReadAddrIn,
    input  logic                            icRE,
    input  logic [31:0]                     icReadAddrIn,
    output logic [FETCH_WIDTH-1:0]          icReadHit,
    output logic [FETCH_WIDTH-1:0][31:0]    icReadDataOut,
    input  logic                            icFlushReq,
    output logic                            icFlushDone,
    output logic                            icBusy,
    output logic                            memReqValid,
    input  logic                            memReqReady,
    output logic [31:0]                     memReqAddr,
    input  logic                            memRspValid,
    input  logic [32*LINE_INSNS-1:0]        memRspData
);
    localparam int WB = $clog2(LINE_INSNS);
    localparam int OB = WB + 2;
    localparam int IB = $clog2(NUM_SETS);
    localparam int TB = 32 - OB - IB;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, REREAD, FLUSH} state_t;

    state_t                   state_q;
    logic [TB-1:0]            tag_q [NUM_SETS];
    logic [32*LINE_INSNS-1:0] data_q [NUM_SETS];
    logic [NUM_SETS-1:0]      valid_q;
    logic [IB-1:0]            rd_idx_q, cnt_q;
    logic [TB-1:0]            rd_tag_q;
    logic                     rd_valid_q, pend_q, hit;
    logic [32*LINE_INSNS-1:0] rd_data_q, line_q;
    logic [LINE_INSNS-1:0][31:0] rd_words;
    logic [IB-1:0]            nidx, midx;
    logic                     unused;

    assign nidx     = icNextReadAddrIn[OB+IB-1:OB];
    assign midx     = memReqAddr[OB+IB-1:OB];
    assign rd_words = rd_data_q;
    assign unused   = ^{icNextReadAddrIn[31:OB+IB], icNextReadAddrIn[OB-1:0], icReadAddrIn[1:0]};

    assign hit = state_q == IDLE && icRE && rd_valid_q && rd_tag_q == icReadAddrIn[31:OB+IB]
               && rd_idx_q == icReadAddrIn[OB+IB-1:OB];
    assign icBusy      = state_q != IDLE;
    assign icFlushDone = state_q == FLUSH && cnt_q == '1 && !icFlushReq;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            icReadHit[i]     = hit;
            icReadDataOut[i] = hit ? rd_words[WB'(icReadAddrIn[OB-1:2] + WB'(i))] : '0;
        end
    end

    // Valid read is forced low while sweeping so nothing cleared during the sweep can look resident after it.
    always_ff @(posedge clk) begin
        rd_idx_q   <= nidx;
        rd_tag_q   <= tag_q[nidx];
        rd_data_q  <= data_q[nidx];
        rd_valid_q <= !rst && state_q != FLUSH && valid_q[nidx];
        if (state_q == WRITE) begin
            tag_q[midx]  <= memReqAddr[31:OB+IB];
            data_q[midx] <= line_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            memReqValid <= 1'b0;
            memReqAddr  <= '0;
        end else begin
            if (icFlushReq && (state_q == REQ || state_q == WAIT || state_q == WRITE))
                pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (icFlushReq) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                    end else if (icRE && !hit) begin
                        state_q     <= REQ;
                        memReqValid <= 1'b1;
                        memReqAddr  <= {icReadAddrIn[31:OB], {OB{1'b0}}};
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        state_q     <= WAIT;
                        memReqValid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (memRspValid) begin
                        state_q <= WRITE;
                        line_q  <= memRspData;
                    end
                end
                WRITE: begin
                    valid_q[midx] <= 1'b1;
                    state_q       <= REREAD;
                end
                REREAD: begin
                    state_q <= (pend_q || icFlushReq) ? FLUSH : IDLE;
                    pend_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                FLUSH: begin
                    valid_q[cnt_q] <= 1'b0;
                    cnt_q          <= icFlushReq ? '0 : cnt_q + 1'b1;
                    if (cnt_q == '1 && !icFlushReq)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder: directed and randomized fetches checked against a set-indexed cache model.
module tb_icache_fetch_responder;
    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       icNextReadAddrIn, icReadAddrIn, memReqAddr;
    logic              icRE, icFlushReq, icFlushDone, icBusy;
    logic              memReqValid, memReqReady, memRspValid;
    logic [1:0]        icReadHit;
    logic [1:0][31:0]  icReadDataOut;
    logic [127:0]      memRspData;

    int tests = 0;
    int fails = 0;

    bit           mv [64];
    logic [21:0]  mt [64];
    logic [127:0] md [64];

    icache_fetch_responder dut (
        .clk(clk), .rst(rst),
        .icNextReadAddrIn(icNextReadAddrIn), .icRE(icRE), .icReadAddrIn(icReadAddrIn),
        .icReadHit(icReadHit), .icReadDataOut(icReadDataOut),
        .icFlushReq(icFlushReq), .icFlushDone(icFlushDone), .icBusy(icBusy),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
        .memRspValid(memRspValid), .memRspData(memRspData)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] r128;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_lanes(input logic [31:0] a, input logic [127:0] d);
        for (int i = 0; i < 2; i++) begin
            int w;
            w = (a[3:2] + i) % 4;
            chk("lane", icReadDataOut[i], d[32*w +: 32]);
        end
    endtask

    task automatic clear_model;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    // One fetch group: hit immediately, or a full refill with n-cycle response, bp stalled request
    // cycles, and an optional flush pulse at cycle fc after miss detection.
    task automatic fetch(input logic [31:0] a, input int n, input int bp, input int fc, input logic [127:0] d);
        int  idx, e, last;
        bit  exp_h;
        idx   = int'(a[9:4]);
        exp_h = mv[idx] && mt[idx] == a[31:10];
        icRE = 1'b0; icReadAddrIn = a; icNextReadAddrIn = a;
        tick;
        icRE = 1'b1;
        #1;
        chk("hit0", icReadHit, exp_h ? 2'b11 : 2'b00);
        if (exp_h) begin
            chk_lanes(a, md[idx]);
            icRE = 1'b0;
            return;
        end
        chk("miss_data0", icReadDataOut, 0);
        e    = n + 4 + bp;
        last = fc >= 0 ? e + 64 : e;
        for (int c = 1; c <= last; c++) begin
            tick;
            memReqReady = (c == 1 + bp) ? 1'b1 : (c < 1 + bp ? 1'b0 : 1'($urandom));
            if (c == 1 + bp + n) begin
                memRspValid = 1'b1;
                memRspData  = d;
            end else begin
                memRspValid = (c <= 1 + bp || c > 1 + bp + n) ? ($urandom_range(0, 3) == 0) : 1'b0;
                memRspData  = r128();
            end
            icFlushReq = (c == fc);
            icRE       = !(fc >= 0 && c >= e);
            #1;
            chk("req_valid", memReqValid, c <= 1 + bp);
            if (c <= 1 + bp) chk("req_addr", memReqAddr, {a[31:4], 4'h0});
            chk("busy", icBusy, c < last);
            chk("flush_done", icFlushDone, fc >= 0 && c == e + 63);
            if (fc < 0 && c == e) begin
                chk("refill_hit", icReadHit, 2'b11);
                chk_lanes(a, d);
            end else if (c < e) begin
                chk("refill_nohit", icReadHit, 2'b00);
                chk("refill_data0", icReadDataOut, 0);
            end
        end
        icRE = 1'b0; memRspValid = 1'b0; memReqReady = 1'b0; icFlushReq = 1'b0;
        if (fc >= 0) clear_model;
        else begin
            mv[idx] = 1'b1; mt[idx] = a[31:10]; md[idx] = d;
        end
    endtask

    // Flush from IDLE; r >= 0 re-pulses the request r cycles into the sweep.
    task automatic idle_flush(input int r);
        int tot;
        tot = r >= 0 ? r + 65 : 64;
        icRE = 1'b0; icFlushReq = 1'b1;
        #1;
        chk("flush_req_idle", icBusy, 1'b0);
        tick;
        for (int k = 0; k <= tot; k++) begin
            icFlushReq = (k == r);
            #1;
            chk("sweep_busy", icBusy, k < tot);
            chk("sweep_done", icFlushDone, k == tot - 1);
            tick;
        end
        icFlushReq = 1'b0;
        clear_model;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; icRE = 1'b0; icReadAddrIn = '0; icNextReadAddrIn = '0;
        icFlushReq = 1'b0; memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
        repeat (2) tick;
        icRE = 1'b1;
        #1;
        chk("rst_hit", icReadHit, 2'b00);
        chk("rst_data", icReadDataOut, 0);
        chk("rst_busy", icBusy, 1'b0);
        chk("rst_req", memReqValid, 1'b0);
        chk("rst_addr", memReqAddr, 0);
        chk("rst_done", icFlushDone, 1'b0);
        icRE = 1'b0;
        rst  = 1'b0;
        tick;
        chk("post_rst_busy", icBusy, 1'b0);
        chk("post_rst_req", memReqValid, 1'b0);

        fetch(32'h0000_1008, 3, 0, -1, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
        fetch(32'h0000_1008, 1, 0, -1, r128());
        fetch(32'h0000_1000, 1, 0, -1, r128());
        fetch(32'h0000_2020, 2, 5, -1, r128());
        fetch(32'h0000_1400, 1, 0, -1, r128());
        fetch(32'h0000_1000, 2, 1, -1, r128());
        fetch(32'h0000_1000, 1, 0, -1, r128());
        fetch(32'h0000_3030, 4, 1, 3, r128());
        fetch(32'h0000_3030, 1, 0, -1, r128());
        idle_flush(-1);
        fetch(32'h0000_3030, 1, 0, -1, r128());
        idle_flush(10);
        fetch(32'h0000_3030, 2, 0, -1, r128());

        for (int t = 0; t < 24; t++) begin
            a = (32'($urandom_range(1, 3)) << 10) | (32'($urandom_range(8, 11)) << 4) | (32'($urandom_range(0, 1)) << 3);
            fetch(a, $urandom_range(1, 5), $urandom_range(0, 2), -1, r128());
        end

        icRE = 1'b0; icReadAddrIn = 32'h0000_5050; icNextReadAddrIn = 32'h0000_5050;
        tick;
        icRE = 1'b1; memReqReady = 1'b1;
        tick;
        tick;
        chk("wait_busy", icBusy, 1'b1);
        chk("wait_req", memReqValid, 1'b0);
        icRE = 1'b0; memReqReady = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0; memRspValid = 1'b1; memRspData = r128();
        #1;
        chk("abandon_busy", icBusy, 1'b0);
        chk("abandon_addr", memReqAddr, 0);
        tick;
        memRspValid = 1'b0;
        #1;
        chk("late_rsp_ignored", icBusy, 1'b0);
        clear_model;
        fetch(32'h0000_5050, 2, 0, -1, r128());
        fetch(32'h0000_3030, 1, 0, -1, r128());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/icache_fetch_responder.md
ICACHE_FETCH_RESPONDER -- requirements
Module: icache_fetch_responder

Interface
REQ-001 Parameter FETCH_WIDTH, 2, instructions returned per fetch group.
REQ-002 Parameter LINE_INSNS, 4, 32-bit instructions per cache line (16-byte line).
REQ-003 Parameter NUM_SETS, 64, direct-mapped sets; address split: [1:0] byte, [3:2] word, [9:4] index, [31:10] tag.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 icNextReadAddrIn  in  32  physical fetch address of next cycle; indexes arrays at clk edge.
REQ-008 icRE  in  1  fetch stage holds a valid group this cycle.
REQ-009 icReadAddrIn  in  32  physical address of lane 0 this cycle; used for tag compare.
REQ-010 icReadHit  out  FETCH_WIDTH x 1  per-lane hit.
REQ-011 icReadDataOut  out  FETCH_WIDTH x 32  per-lane instruction.
REQ-012 icFlushReq  in  1  invalidate-all request, one-cycle pulse.
REQ-013 icFlushDone  out  1  one-cycle pulse at end of flush sweep.
REQ-014 icBusy  out  1  FSM not IDLE.
REQ-015 memReqValid / memReqReady  out / in  1 / 1  refill request handshake.
REQ-016 memReqAddr  out  32  line-aligned refill address (low 4 bits zero).
REQ-017 memRspValid / memRspData  in / in  1 / 128  refill data; word w at bits [32w+31:32w].

Function
REQ-018 Arrays (tag, valid, data) SHALL be read synchronously: index of icNextReadAddrIn sampled each edge; lookup result valid the following cycle.
REQ-019 Fetch groups are FETCH_WIDTH-aligned and never cross a line; lane i SHALL return word (icReadAddrIn[3:2]+i) of the read line.
REQ-020 icReadHit[i] SHALL be 1 only when state==IDLE, icRE==1, read valid bit==1, stored tag==icReadAddrIn[31:10], and latched read index==icReadAddrIn[9:4]; all lanes carry the same hit value.
REQ-021 icReadDataOut SHALL be 0 on any lane whose hit is 0.
REQ-022 FSM states: IDLE, REQ, WAIT, WRITE, REREAD, FLUSH.
REQ-023 IDLE->REQ when icRE && !hit; miss line address latched at that edge.
REQ-024 REQ: memReqValid=1, memReqAddr stable; ->WAIT on memReqValid&&memReqReady in same cycle.
REQ-025 WAIT: ->WRITE on memRspValid; memRspData captured; memRspValid in any other state SHALL be ignored.
REQ-026 WRITE: one cycle; data, tag, valid=1 written at latched index; ->REREAD.
REQ-027 REREAD: one cycle, hit forced 0, arrays re-read from icNextReadAddrIn; ->IDLE (or FLUSH if flush pending).
REQ-028 Miss-to-hit latency with memReqReady=1 and response N cycles after acceptance SHALL be N+4 cycles from miss detection.
REQ-029 Only one refill outstanding; no new miss accepted until IDLE.
REQ-030 icFlushReq in IDLE SHALL enter FLUSH; in any other state SHALL set a pending flag serviced after REREAD.
REQ-031 FLUSH: 6-bit counter clears one valid bit per cycle, index 0..63; icFlushDone pulses on the cycle index 63 is cleared; ->IDLE; total 64 cycles.
REQ-032 icFlushReq during FLUSH SHALL restart the counter at 0.
REQ-033 icBusy SHALL equal (state!=IDLE).

Reset
REQ-034 On rst: state=IDLE, all valid bits 0 (single cycle), flush pending=0, counter=0.
REQ-035 Outputs during/after reset: icReadHit=0, icReadDataOut=0, memReqValid=0, memReqAddr=0, icFlushDone=0, icBusy=0.
REQ-036 rst mid-refill or mid-flush SHALL abandon it; later memRspValid ignored.

Verification
REQ-037 Cold miss: icRE=1, addr 0x0000_1008 -> hit=0, memReqAddr=0x0000_1000; rsp data words {A,B,C,D} -> hit=1, lanes=C,D.
REQ-038 Back-pressure: memReqReady=0 for 5 cycles -> memReqValid held, memReqAddr unchanged, state REQ.
REQ-039 Conflict: line 0x1000 resident, fetch 0x1400 (same index 0, tag differs) -> miss, refill replaces line; refetch 0x1000 misses again.
REQ-040 Flush during WAIT -> refill completes, then 64-cycle FLUSH, icFlushDone pulses once, prior line misses.
REQ-041 Reset in WAIT then memRspValid=1 -> no array write, state IDLE, all lookups miss.
